// File: rtl/fudan_pkg.sv
// -----------------------------------------------------------------------------
// fudan_pkg
// Shared definitions for the run-length measurement path feeding the
// fudan17-style pattern detector.
//   run_class_t : 2-bit classification of a completed high run
//   run_state_t : sequencing states of the run-length controller
// -----------------------------------------------------------------------------
package fudan_pkg;

  typedef enum logic [1:0] {
    CLS_SHORT = 2'b00,
    CLS_OK    = 2'b01,
    CLS_LONG  = 2'b10,
    CLS_SAT   = 2'b11
  } run_class_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    WAIT = 2'b10,
    MEAS = 2'b11
  } run_state_t;

endpackage

// File: rtl/run_out_buf.sv
// -----------------------------------------------------------------------------
// run_out_buf
// One-entry valid/ready holding register for completed run results.
// A new result is taken when the buffer is empty or is being drained on the
// same edge; otherwise it is dropped and the sticky overflow flag is set.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   i_load          : a completed result is offered this cycle
//   i_len, i_cls    : offered run length and class
//   i_ready         : consumer accepts the held result
//   o_accept        : combinational, i_load will be stored on this edge
//   o_valid         : held result available
//   o_len, o_cls    : held run length and class
//   o_overflow      : sticky, a result was dropped to backpressure
// -----------------------------------------------------------------------------
module run_out_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_len,
  input  logic [1:0]   i_cls,
  input  logic         i_ready,
  output logic         o_accept,
  output logic         o_valid,
  output logic [W-1:0] o_len,
  output logic [1:0]   o_cls,
  output logic         o_overflow
);

  logic         r_valid;
  logic [W-1:0] r_len;
  logic [1:0]   r_cls;
  logic         r_overflow;

  // Only a full buffer that is not being drained refuses a new result.
  assign o_accept = i_load && !(r_valid && !i_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_len      <= '0;
      r_cls      <= 2'b00;
      r_overflow <= 1'b0;
    end else begin
      if (o_accept) begin
        r_valid <= 1'b1;
        r_len   <= i_len;
        r_cls   <= i_cls;
      end else if (r_valid && i_ready) begin
        // Drained: data fields keep their last value.
        r_valid <= 1'b0;
      end
      if (i_load && !o_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_len      = r_len;
  assign o_cls      = r_cls;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/run_len_ctrl.sv
// -----------------------------------------------------------------------------
// run_len_ctrl
// Measures high runs on the serial input. After enable it first waits for a
// low level (a run already in progress is never measured), then counts each
// run of consecutive high cycles and classifies it against min_len/max_len
// when the first low cycle is sampled. Results go through a one-entry
// valid/ready buffer.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in                  : serial input
//   enable              : measurement enable, low forces IDLE
//   min_len, max_len    : in-range limits, sampled at run end
//   len_out, class_out  : held result (length, class)
//   out_valid/out_ready : result handshake
//   hit                 : one-cycle pulse when an OK result is loaded
//   overflow            : sticky, a result was dropped
//   busy                : a run is being counted
// -----------------------------------------------------------------------------
module run_len_ctrl
  import fudan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             enable,
  input  logic [CNT_W-1:0] min_len,
  input  logic [CNT_W-1:0] max_len,
  output logic [CNT_W-1:0] len_out,
  output logic [1:0]       class_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             hit,
  output logic             overflow,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  run_state_t       r_state;
  run_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done;
  run_class_t       w_cls;
  logic             w_accept;
  logic             r_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hit   <= w_accept && (w_cls == CLS_OK);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done       = 1'b0;
    if (!enable) begin
      // Dropping enable abandons any run in progress without a report.
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: w_state_next = ARM;
        ARM: begin
          if (!in) w_state_next = WAIT;
        end
        WAIT: begin
          if (in) begin
            w_cnt_next   = CNT_W'(1);
            w_state_next = MEAS;
          end
        end
        MEAS: begin
          if (in) begin
            if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + 1'b1;
          end else begin
            w_done       = 1'b1;
            w_cnt_next   = '0;
            w_state_next = WAIT;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Priority: saturation, then short, then long. With min_len > max_len the
  // OK window is empty, so such a run always lands in SHORT or LONG.
  always_comb begin
    if (r_cnt == CNT_MAX)      w_cls = CLS_SAT;
    else if (r_cnt < min_len)  w_cls = CLS_SHORT;
    else if (r_cnt > max_len)  w_cls = CLS_LONG;
    else                       w_cls = CLS_OK;
  end

  run_out_buf #(.W(CNT_W)) u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_done),
    .i_len      (r_cnt),
    .i_cls      (w_cls),
    .i_ready    (out_ready),
    .o_accept   (w_accept),
    .o_valid    (out_valid),
    .o_len      (len_out),
    .o_cls      (class_out),
    .o_overflow (overflow)
  );

  assign hit  = r_hit;
  assign busy = (r_state == MEAS);

endmodule

// File: tb/tb_run_len_ctrl.sv
// -----------------------------------------------------------------------------
// tb_run_len_ctrl
// Two instances share all inputs: dut0 with CNT_W=8 and dut1 with CNT_W=4
// (limits truncated to 4 bits). A behavioural model tracks "armed since a
// low after enable", the current run length and the one-entry result buffer,
// and every output of both instances is compared on each falling edge.
// Directed tests add literal expectations on the transferred results.
// -----------------------------------------------------------------------------
module tb_run_len_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in = 1'b0;
  logic       enable = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] min_len = 8'd6;
  logic [7:0] max_len = 8'd27;
  logic [3:0] min4, max4;

  logic [7:0] len0;
  logic [1:0] cls0;
  logic       val0, hit0, ovf0, busy0;
  logic [3:0] len1;
  logic [1:0] cls1;
  logic       val1, hit1, ovf1, busy1;

  int n_err = 0;
  int n_checks = 0;

  assign min4 = min_len[3:0];
  assign max4 = max_len[3:0];

  always #5 clk = ~clk;

  run_len_ctrl #(.CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .in(in), .enable(enable),
    .min_len(min_len), .max_len(max_len),
    .len_out(len0), .class_out(cls0), .out_valid(val0), .out_ready(out_ready),
    .hit(hit0), .overflow(ovf0), .busy(busy0)
  );

  run_len_ctrl #(.CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .in(in), .enable(enable),
    .min_len(min4), .max_len(max4),
    .len_out(len1), .class_out(cls1), .out_valid(val1), .out_ready(out_ready),
    .hit(hit1), .overflow(ovf1), .busy(busy1)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit en_seen;   // enable was high on a previous edge
    bit armed;     // a low level has been seen since enable
    int run;       // current high-run length, 0 when not in a run
    int len;
    int cls;
    bit valid;
    bit hit;
    bit ovf;
  } ms_t;

  ms_t m0, m1;

  function automatic ms_t step(ms_t s, int sat, int mn, int mx,
                               bit i_in, bit i_en, bit rdy);
    ms_t n = s;
    bit  done = 1'b0;
    int  c;
    n.hit = 1'b0;
    if (!i_en) begin
      n.en_seen = 1'b0;
      n.armed   = 1'b0;
      n.run     = 0;
    end else begin
      n.en_seen = 1'b1;
      if (!s.armed) begin
        if (s.en_seen && !i_in) n.armed = 1'b1;
      end else if (i_in) begin
        n.run = (s.run < sat) ? s.run + 1 : sat;
      end else begin
        done  = (s.run > 0);
        n.run = 0;
      end
    end
    if (done) begin
      if (s.run == sat)     c = 3;
      else if (s.run < mn)  c = 0;
      else if (s.run > mx)  c = 2;
      else                  c = 1;
      if (s.valid && !rdy) begin
        n.ovf = 1'b1;
      end else begin
        n.len   = s.run;
        n.cls   = c;
        n.valid = 1'b1;
        n.hit   = (c == 1);
      end
    end else if (s.valid && rdy) begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= step(m0, 255, int'(min_len), int'(max_len), in, enable, out_ready);
      m1 <= step(m1, 15, int'(min4), int'(max4), in, enable, out_ready);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("len0",  32'(len0),  m0.len);
    chk("cls0",  32'(cls0),  m0.cls);
    chk("val0",  32'(val0),  int'(m0.valid));
    chk("hit0",  32'(hit0),  int'(m0.hit));
    chk("ovf0",  32'(ovf0),  int'(m0.ovf));
    chk("busy0", 32'(busy0), int'(m0.run > 0));
    chk("len1",  32'(len1),  m1.len);
    chk("cls1",  32'(cls1),  m1.cls);
    chk("val1",  32'(val1),  int'(m1.valid));
    chk("hit1",  32'(hit1),  int'(m1.hit));
    chk("ovf1",  32'(ovf1),  int'(m1.ovf));
    chk("busy1", 32'(busy1), int'(m1.run > 0));
  end

  // ---------------- transfer monitor for literal checks ----------------
  int q_len[$];
  int q_cls[$];
  int hits0 = 0;
  int vcyc0 = 0;

  always @(negedge clk) begin
    if (val0 && out_ready) begin
      q_len.push_back(int'(len0));
      q_cls.push_back(int'(cls0));
      $display("xfer len=%0d class=%0d at %0t", len0, cls0, $time);
    end
    if (hit0) hits0++;
    if (val0) vcyc0++;
  end

  task automatic clear_mon();
    q_len.delete();
    q_cls.delete();
    hits0 = 0;
    vcyc0 = 0;
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic run(input int hi, input int lo);
    in = 1'b1;
    step_n(hi);
    in = 1'b0;
    step_n(lo);
  endtask

  int sw_len[5] = '{8, 15, 21, 27, 35};
  int sw_gap[5] = '{4, 4, 5, 7, 8};
  int sw_cls[5] = '{1, 1, 1, 1, 2};

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("reset_val0",  32'(val0),  0);
    chk("reset_len0",  32'(len0),  0);
    chk("reset_busy0", 32'(busy0), 0);
    step_n(2);
    reset  = 1'b0;
    enable = 1'b1;
    in     = 1'b0;
    step_n(4);

    // Basic run of 6
    clear_mon();
    run(6, 3);
    chk("t1_count", 32'(q_len.size()), 1);
    chk("t1_len",   32'(q_len[0]), 6);
    chk("t1_cls",   32'(q_cls[0]), 1);
    chk("t1_hits",  32'(hits0), 1);
    chk("t1_vcyc",  32'(vcyc0), 1);

    // Long-pattern sweep
    clear_mon();
    for (int i = 0; i < 5; i++) run(sw_len[i], sw_gap[i]);
    chk("t2_count", 32'(q_len.size()), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_len", 32'(q_len[i]), sw_len[i]);
      chk("t2_cls", 32'(q_cls[i]), sw_cls[i]);
    end
    chk("t2_hits", 32'(hits0), 4);

    // Enable asserted while in is high
    clear_mon();
    enable = 1'b0;
    step_n(2);
    in     = 1'b1;
    enable = 1'b1;
    step_n(3);
    in = 1'b0;
    step_n(3);
    run(2, 3);
    chk("t3_count", 32'(q_len.size()), 1);
    chk("t3_len",   32'(q_len[0]), 2);
    chk("t3_cls",   32'(q_cls[0]), 0);

    // Completion on the same edge as a transfer
    clear_mon();
    out_ready = 1'b0;
    run(6, 3);
    chk("t4_hold_len", 32'(len0), 6);
    chk("t4_hold_val", 32'(val0), 1);
    in = 1'b1;
    step_n(8);
    in        = 1'b0;
    out_ready = 1'b1;
    step_n(3);
    chk("t4_count", 32'(q_len.size()), 2);
    chk("t4_len_a", 32'(q_len[0]), 6);
    chk("t4_len_b", 32'(q_len[1]), 8);
    chk("t4_ovf",   32'(ovf0), 0);

    // Backpressure drop
    clear_mon();
    out_ready = 1'b0;
    run(6, 3);
    run(8, 3);
    chk("t5_len", 32'(len0), 6);
    chk("t5_val", 32'(val0), 1);
    chk("t5_ovf", 32'(ovf0), 1);
    out_ready = 1'b1;
    step_n(2);
    chk("t5_val_after", 32'(val0), 0);
    chk("t5_count",     32'(q_len.size()), 1);
    chk("t5_xfer_len",  32'(q_len[0]), 6);

    // Saturation on the 4-bit instance
    clear_mon();
    run(20, 3);
    chk("t6_len1", 32'(len1), 15);
    chk("t6_cls1", 32'(cls1), 3);
    chk("t6_len0", 32'(q_len[0]), 20);
    chk("t6_cls0", 32'(q_cls[0]), 1);

    // Reset in the middle of a run
    in = 1'b1;
    step_n(3);
    chk("t7_busy_pre", 32'(busy0), 1);
    reset = 1'b1;
    in    = 1'b0;
    #1;
    chk("t7_val",  32'(val0),  0);
    chk("t7_len",  32'(len0),  0);
    chk("t7_cls",  32'(cls0),  0);
    chk("t7_ovf",  32'(ovf0),  0);
    chk("t7_hit",  32'(hit0),  0);
    chk("t7_busy", 32'(busy0), 0);
    step_n(2);
    reset = 1'b0;
    step_n(3);
    clear_mon();
    run(6, 3);
    chk("t7_count", 32'(q_len.size()), 1);
    chk("t7_rlen",  32'(q_len[0]), 6);
    chk("t7_rcls",  32'(q_cls[0]), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/run_len_ctrl.md
Name: run_len_ctrl

Overview:
- Controller that sequences run-length measurement of the serial `in` stream feeding the fudan17-style pattern detector.
- Arms on a low level, counts consecutive high cycles, and classifies each completed run against programmable limits.
- Holds the result in a one-entry valid/ready output buffer and flags any result dropped to backpressure.
- Sits between the serial source and downstream pattern logic and acts as the scheduler deciding which runs are reported.

Parameters:
- CNT_W, 8, run counter and length field width; counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset; clears all state and outputs.
- in  in  1  serial input, synchronous to clk.
- enable  in  1  measurement enable; low forces IDLE.
- min_len  in  CNT_W  smallest in-range run length, sampled at run end.
- max_len  in  CNT_W  largest in-range run length, sampled at run end.
- len_out  out  CNT_W  measured run length, in cycles.
- class_out  out  2  run class: 00 SHORT, 01 OK, 10 LONG, 11 SAT.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- hit  out  1  one-cycle pulse when a class-OK result is loaded.
- overflow  out  1  sticky flag: a result was dropped.
- busy  out  1  high in MEAS.

Behaviour:
- Reset values: len_out=0, class_out=00, out_valid=0, hit=0, overflow=0, busy=0, state=IDLE, cnt=0.
- FSM states:
  - IDLE: go to ARM when enable=1.
  - ARM: wait for in=0, then go to WAIT. A run already high at enable is never measured.
  - WAIT: on in=1, set cnt<=1 and go to MEAS.
  - MEAS: while in=1, cnt<=cnt+1, saturating at 2^CNT_W-1. On in=0, complete the run and go to WAIT.
- enable=0 in any state: next state IDLE, cnt cleared, an in-progress run discarded with no report. Buffered output is untouched.
- Classification at completion, evaluated in priority order:
  - SAT if cnt==2^CNT_W-1.
  - else SHORT if cnt<min_len.
  - else LONG if cnt>max_len.
  - else OK.
  - If min_len>max_len, no run classifies OK.
- Completion latency: the edge that samples the first in=0 loads len_out/class_out and sets out_valid. These are visible in the following cycle.
- Run of N high cycles reports len_out=N, for N < 2^CNT_W-1.
- hit pulses for exactly one cycle, coincident with the load of an OK result.
- Handshake:
  - Transfer occurs on a cycle with out_valid=1 and out_ready=1.
  - Output is stable while out_valid=1 and out_ready=0.
  - After transfer with no new completion, out_valid<=0 and len_out/class_out hold their last value.
- Completion while out_valid=1 and out_ready=0: new result dropped, buffer kept, overflow<=1. overflow clears only on reset.
- Completion on the same edge as a transfer: new result loaded, out_valid stays 1, no overflow.
- Minimum low gap is 1 cycle: pattern 1,0,1 yields two runs of length 1.
- Reset mid-run or mid-handshake: immediate return to reset values; no partial result.

Decomposition:
- Shared package fudan_pkg holds:
  - the 2-bit class typedef/constants (CLS_SHORT, CLS_OK, CLS_LONG, CLS_SAT);
  - the FSM state encoding (IDLE, ARM, WAIT, MEAS).
- Optional sub-module run_out_buf: one-entry valid/ready holding register with drop detection.
- Counter, FSM and classifier stay in the top.

Test Plan:
- Basic run classification. Setup: reset for 2 cycles, enable=1, min=6, max=27, out_ready=1. Stimulus: in low 1 cycle, high 6 cycles, low. Response: len_out=6, class=OK, hit pulse one cycle, out_valid for one cycle.
- Long-pattern sweep. Stimulus: high runs of 8/15/21/27/35 separated by low gaps of 4/4/5/7/8. Response: lengths 8,15,21,27 class OK; 35 class LONG; hit exactly 4 times.
- Enable while high. Stimulus: enable asserted while in=1 for 3 cycles, then low, then high 2 cycles. Response: first run ignored; single result len=2, class SHORT.
- Backpressure drop. Stimulus: out_ready=0 across two completed runs (6, then 8). Response: output holds len=6, overflow=1 after second completion. Then raise out_ready: transfer, out_valid=0.
- Saturation with CNT_W=4. Stimulus: 20 high cycles. Response: len_out=15, class SAT. Also a completion coinciding with a transfer: no overflow.
- Reset mid-MEAS. Stimulus: reset asserted after 3 high cycles. Response: all outputs 0 the same cycle, no report. After release, next full run measured correctly.
